bcd_counter_disp: RTL and testbench

- Parametrised multi-digit BCD counter with per-digit 7-segment decode.
- Adds a clock prescaler, enable, up/down counting, parallel load, a terminal-count pulse and optional leading-zero blanking.
- Sits between the board clock/switches and the HEX display pins; it is the general counting/display front end for the lab designs.

---
 rtl/bcd_counter_disp.sv | 143 ++++++++++++++
 tb/tb_bcd_counter_disp.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_disp.sv
// Purpose : multi-digit BCD up/down counter with prescaler, parallel load,
//           terminal-count pulse and per-digit active-low 7-segment decode.
// Latency : count/tc update on the tick edge; hex is combinational from count.
// Backpressure: none; the counter advances whenever a tick occurs.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   en             gates both the prescaler and count ticks
//   up_dn          1 = count up, 0 = count down
//   load, load_val parallel load (digits >9 load as 0), wins over a tick
//   blank_lz       blank leading zero digits (digit 0 always lit)
//   count          registered BCD value, digit i at [4i+3:4i]
//   hex            active-low segments, digit i at [7i+6:7i], bit0 = seg a
//   tc             one-cycle pulse coincident with the wrapped count value
module bcd_counter_disp #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  blank_lz,
  output logic [4*DIGITS-1:0]   count,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  tc
);

  localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]       pre;
  logic                tick;
  logic [4*DIGITS-1:0] cnt_step;
  logic [4*DIGITS-1:0] cnt_load;
  logic                wrap;
  logic [DIGITS-1:0]   blank;

  assign tick = en && (pre == PRE_LAST);

  // Ripple carry/borrow across digits in one cycle. The carry entering the
  // loop is the tick itself; if it survives every digit the counter wrapped.
  always_comb begin : step_logic
    logic       carry;
    logic [3:0] d;
    cnt_step = count;
    carry    = 1'b1;
    d        = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      d = count[4*i +: 4];
      if (carry) begin
        if (up_dn) begin
          if (d == 4'd9) begin
            cnt_step[4*i +: 4] = 4'd0;
          end else begin
            cnt_step[4*i +: 4] = d + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            cnt_step[4*i +: 4] = 4'd9;
          end else begin
            cnt_step[4*i +: 4] = d - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    wrap = carry;
  end

  // Non-BCD load digits are forced to 0 so count only ever holds 0..9.
  always_comb begin : load_logic
    logic [3:0] d;
    d = 4'd0;
    cnt_load = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = load_val[4*i +: 4];
      cnt_load[4*i +: 4] = (d > 4'd9) ? 4'd0 : d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      pre   <= '0;
      tc    <= 1'b0;
    end else if (load) begin
      count <= cnt_load;
      pre   <= '0;
      tc    <= 1'b0;
    end else begin
      tc <= tick && wrap;
      if (tick) begin
        count <= cnt_step;
        pre   <= '0;
      end else if (en) begin
        pre <= pre + 1'b1;
      end
    end
  end

  // Walk from the most significant digit down, tracking whether every digit
  // seen so far is zero.
  always_comb begin : blank_logic
    logic zero_above;
    logic dz;
    zero_above = 1'b1;
    dz         = 1'b0;
    blank      = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dz         = (count[4*i +: 4] == 4'd0);
      blank[i]   = blank_lz && zero_above && dz && (i != 0);
      zero_above = zero_above && dz;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    hex = '0;
    for (int i = 0; i < DIGITS; i++) begin
      hex[7*i +: 7] = blank[i] ? 7'b1111111 : seg7(count[4*i +: 4]);
    end
  end

endmodule

// File: tb/tb_bcd_counter_disp.sv
// Bench for bcd_counter_disp: four instances with different DIGITS/PRESCALE
// share one set of inputs; an integer-valued model tracks every instance.
// Latency: outputs checked #1 after each rising edge.
module tb_bcd_counter_disp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, en = 1'b0, up_dn = 1'b1, load = 1'b0, blank_lz = 1'b0;
  logic [15:0] lv = '0;

  logic [7:0]  c0, c1;
  logic [11:0] c2;
  logic [15:0] c3;
  logic [13:0] h0, h1;
  logic [20:0] h2;
  logic [27:0] h3;
  logic        t0, t1, t2, t3;

  bcd_counter_disp #(.DIGITS(2), .PRESCALE(3)) u0 (.clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
    .load(load), .load_val(lv[7:0]), .blank_lz(blank_lz), .count(c0), .hex(h0), .tc(t0));
  bcd_counter_disp #(.DIGITS(2), .PRESCALE(1)) u1 (.clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
    .load(load), .load_val(lv[7:0]), .blank_lz(blank_lz), .count(c1), .hex(h1), .tc(t1));
  bcd_counter_disp #(.DIGITS(3), .PRESCALE(4)) u2 (.clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
    .load(load), .load_val(lv[11:0]), .blank_lz(blank_lz), .count(c2), .hex(h2), .tc(t2));
  bcd_counter_disp #(.DIGITS(4), .PRESCALE(1)) u3 (.clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
    .load(load), .load_val(lv[15:0]), .blank_lz(blank_lz), .count(c3), .hex(h3), .tc(t3));

  logic [31:0] dcnt [4];
  logic [55:0] dhex [4];
  logic        dtc  [4];
  always_comb begin
    dcnt[0] = 32'(c0); dcnt[1] = 32'(c1); dcnt[2] = 32'(c2); dcnt[3] = 32'(c3);
    dhex[0] = 56'(h0); dhex[1] = 56'(h1); dhex[2] = 56'(h2); dhex[3] = 56'(h3);
    dtc[0]  = t0;      dtc[1]  = t1;      dtc[2]  = t2;      dtc[3]  = t3;
  end

  // Reference model: each counter is a plain integer modulo 10^DIGITS.
  int ND [4] = '{2, 2, 3, 4};
  int NP [4] = '{3, 1, 4, 1};
  int mval [4];
  int mpre [4];
  bit mtc  [4];
  bit mvalid = 1'b0;

  logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int sanitize(input logic [15:0] v, input int d);
    int r = 0;
    int m = 1;
    int nib;
    for (int i = 0; i < d; i++) begin
      nib = int'(v[4*i +: 4]);
      if (nib > 9) nib = 0;
      r = r + nib * m;
      m = m * 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int d);
    logic [31:0] r = '0;
    int x = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [55:0] exp_hex(input int v, input int d, input logic blz);
    logic [55:0] r = '0;
    int p;
    for (int i = 0; i < d; i++) begin
      p = pow10(i);
      if (blz && i > 0 && v < p) r[7*i +: 7] = 7'b1111111;
      else                       r[7*i +: 7] = SEG[(v / p) % 10];
    end
    return r;
  endfunction

  task automatic model_step();
    int m;
    bit tick;
    for (int k = 0; k < 4; k++) begin
      m = pow10(ND[k]);
      if (rst) begin
        mval[k] = 0; mpre[k] = 0; mtc[k] = 1'b0;
      end else if (load) begin
        mval[k] = sanitize(lv, ND[k]); mpre[k] = 0; mtc[k] = 1'b0;
      end else begin
        tick = en && (mpre[k] == NP[k] - 1);
        mtc[k] = 1'b0;
        if (en) mpre[k] = tick ? 0 : mpre[k] + 1;
        if (tick) begin
          if (up_dn) begin
            mtc[k] = (mval[k] == m - 1);
            mval[k] = (mval[k] + 1) % m;
          end else begin
            mtc[k] = (mval[k] == 0);
            mval[k] = (mval[k] + m - 1) % m;
          end
        end
      end
    end
    if (rst) mvalid = 1'b1;
  endtask

  task automatic check_all();
    if (mvalid) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("model u%0d count", k), 64'(dcnt[k]), 64'(to_bcd(mval[k], ND[k])));
        chk($sformatf("model u%0d tc", k), 64'(dtc[k]), 64'(mtc[k]));
        chk($sformatf("model u%0d hex", k), 64'(dhex[k]), 64'(exp_hex(mval[k], ND[k], blank_lz)));
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Vectors for the DIGITS=2, PRESCALE=1 instance (u1).
  typedef struct { int r; int e; int u; int l; int v; int cnt; int t; } vec_t;
  vec_t tbl [16];

  initial begin
    int rv;

    tbl[0]  = '{1, 0, 1, 0, 'h0000, 'h00, 0};
    tbl[1]  = '{0, 1, 1, 1, 'h0098, 'h98, 0};
    tbl[2]  = '{0, 1, 1, 0, 'h0000, 'h99, 0};
    tbl[3]  = '{0, 1, 1, 0, 'h0000, 'h00, 1};
    tbl[4]  = '{0, 1, 1, 0, 'h0000, 'h01, 0};
    tbl[5]  = '{0, 0, 0, 1, 'h0001, 'h01, 0};
    tbl[6]  = '{0, 1, 0, 0, 'h0000, 'h00, 0};
    tbl[7]  = '{0, 1, 0, 0, 'h0000, 'h99, 1};
    tbl[8]  = '{0, 1, 0, 0, 'h0000, 'h98, 0};
    tbl[9]  = '{0, 1, 0, 1, 'h00A5, 'h05, 0};
    tbl[10] = '{0, 1, 1, 1, 'h0099, 'h99, 0};
    tbl[11] = '{0, 1, 1, 0, 'h0000, 'h00, 1};
    tbl[12] = '{0, 0, 1, 1, 'h009F, 'h90, 0};
    tbl[13] = '{0, 0, 1, 0, 'h0000, 'h90, 0};
    tbl[14] = '{1, 1, 1, 1, 'h0055, 'h00, 0};
    tbl[15] = '{0, 1, 0, 0, 'h0000, 'h99, 1};

    // Prescale-by-3 counting from reset.
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; blank_lz = 1'b0;
    cyc();
    chk("reset count", 64'(c0), 64'h00);
    chk("reset tc", 64'(t0), 64'h0);
    chk("reset hex", 64'(h0), 64'({7'b1000000, 7'b1000000}));
    rst = 1'b0; en = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      cyc();
      chk($sformatf("prescale tc n=%0d", n), 64'(t0), 64'h0);
      if (n == 2) chk("prescale count n=2", 64'(c0), 64'h00);
      if (n == 3) begin
        chk("prescale count n=3", 64'(c0), 64'h01);
        chk("prescale hex0 at 01", 64'(h0[6:0]), 64'(7'b1111001));
      end
      if (n == 6) chk("prescale count n=6", 64'(c0), 64'h02);
    end

    // Table-driven load/wrap/tc vectors.
    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].r[0]; en = tbl[i].e[0]; up_dn = tbl[i].u[0];
      load = tbl[i].l[0]; lv = tbl[i].v[15:0];
      cyc();
      chk($sformatf("vec%0d count", i), 64'(c1), 64'(tbl[i].cnt));
      chk($sformatf("vec%0d tc", i), 64'(t1), 64'(tbl[i].t));
    end

    // Prescaler freezes while en=0, then load beats a coincident tick.
    rst = 1'b1; en = 1'b0; load = 1'b0; up_dn = 1'b1;
    cyc();
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      en = (n == 2 || n == 3) ? 1'b0 : 1'b1;
      cyc();
      if (n == 4) chk("freeze count before 4th", 64'(c2), 64'h000);
    end
    chk("freeze count at 4th enabled", 64'(c2), 64'h001);
    en = 1'b1;
    repeat (3) cyc();
    chk("pre-load count", 64'(c2), 64'h001);
    load = 1'b1; lv = 16'h0123;
    cyc();
    load = 1'b0;
    chk("load over tick count", 64'(c2), 64'h123);
    chk("load over tick tc", 64'(t2), 64'h0);

    // Leading-zero blanking on the 4-digit instance.
    en = 1'b0; blank_lz = 1'b1; load = 1'b1; lv = 16'h0070;
    cyc();
    load = 1'b0;
    chk("blank 0070 d3", 64'(h3[27:21]), 64'(7'b1111111));
    chk("blank 0070 d2", 64'(h3[20:14]), 64'(7'b1111111));
    chk("blank 0070 d1", 64'(h3[13:7]),  64'(7'b1111000));
    chk("blank 0070 d0", 64'(h3[6:0]),   64'(7'b1000000));
    load = 1'b1; lv = 16'h0000;
    cyc();
    load = 1'b0;
    chk("blank 0000", 64'(h3), 64'({7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}));
    blank_lz = 1'b0;
    #1;
    chk("noblank 0000", 64'(h3), 64'({4{7'b1000000}}));

    // Reset in the middle of a prescale period.
    rst = 1'b1;
    cyc();
    rst = 1'b0; load = 1'b1; lv = 16'h0057;
    cyc();
    load = 1'b0; en = 1'b1;
    cyc();
    cyc();
    chk("mid count before rst", 64'(c0), 64'h57);
    rst = 1'b1;
    cyc();
    chk("mid rst count", 64'(c0), 64'h00);
    chk("mid rst tc", 64'(t0), 64'h0);
    rst = 1'b0;
    cyc();
    cyc();
    chk("after rst 2 cycles", 64'(c0), 64'h00);
    cyc();
    chk("after rst 3 cycles", 64'(c0), 64'h01);

    // Randomised traffic, checked against the model every cycle.
    for (int n = 0; n < 600; n++) begin
      rst  = ($urandom_range(0, 49) == 0);
      load = ($urandom_range(0, 9) == 0);
      en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) up_dn = ~up_dn;
      if ($urandom_range(0, 3) == 0) blank_lz = ~blank_lz;
      rv = int'($urandom_range(0, 3));
      case (rv)
        0:       lv = 16'h9998;
        1:       lv = 16'h0001;
        default: lv = 16'($urandom);
      endcase
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
